// File: rtl/param_stack.sv
// Parametrised LIFO for return-address and operand storage.
// Replace-top on push+pop, sticky error flags, and an indexed read port.
module param_stack #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  push_en,
    input  logic                  pop_en,
    input  logic [WIDTH-1:0]      din,
    input  logic                  err_clr,
    input  logic [DEPTH_LOG2-1:0] peek_idx,
    output logic [WIDTH-1:0]      top,
    output logic [WIDTH-1:0]      peek_data,
    output logic                  peek_hit,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] top_ptr;
    logic [DEPTH_LOG2-1:0] peek_ptr;
    logic                  ovf_event;
    logic                  unf_event;

    // Low bits of count wrap to 0 when full, so count-1 still lands on DEPTH-1.
    assign wr_ptr   = count_q[DEPTH_LOG2-1:0];
    assign top_ptr  = wr_ptr - DEPTH_LOG2'(1);
    assign peek_ptr = top_ptr - peek_idx;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign top       = empty ? '0 : mem_q[top_ptr];
    assign peek_hit  = ({1'b0, peek_idx} < count_q);
    assign peek_data = peek_hit ? mem_q[peek_ptr] : '0;

    always_comb begin
        mem_d     = mem_q;
        count_d   = count_q;
        ovf_event = 1'b0;
        unf_event = 1'b0;

        if (push_en && pop_en) begin
            if (empty) begin
                mem_d[0] = din;
                count_d  = CNT_W'(1);
            end else begin
                mem_d[top_ptr] = din;
            end
        end else if (push_en) begin
            if (full) begin
                ovf_event = 1'b1;
            end else begin
                mem_d[wr_ptr] = din;
                count_d       = count_q + CNT_W'(1);
            end
        end else if (pop_en) begin
            if (empty) begin
                unf_event = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end

        // A new error in the same cycle as err_clr keeps the flag set.
        overflow_d  = ovf_event | (overflow_q & ~err_clr);
        underflow_d = unf_event | (underflow_q & ~err_clr);

        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q       <= mem_d;
        count_q     <= count_d;
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
    end

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack (WIDTH=8, DEPTH_LOG2=2).
// Expected outputs are queued per stimulus and compared after each edge.
module tb_param_stack;

    logic       clk = 1'b0;
    logic       clr, push_en, pop_en, err_clr;
    logic [7:0] din;
    logic [1:0] peek_idx;
    logic [7:0] top, peek_data;
    logic       peek_hit, full, empty, overflow, underflow;
    logic [2:0] count;

    typedef struct packed {
        logic [7:0] top;
        logic [7:0] peek_data;
        logic       peek_hit;
        logic [2:0] count;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } obs_t;

    obs_t exp_q[$];
    obs_t got_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0] m_mem [4];
    int         m_cnt = 0;
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    param_stack #(.WIDTH(8), .DEPTH_LOG2(2)) dut (
        .clk(clk), .clr(clr), .push_en(push_en), .pop_en(pop_en),
        .din(din), .err_clr(err_clr), .peek_idx(peek_idx),
        .top(top), .peek_data(peek_data), .peek_hit(peek_hit),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.top = top;
        o.peek_data = peek_data;
        o.peek_hit = peek_hit;
        o.count = count;
        o.full = full;
        o.empty = empty;
        o.ovf = overflow;
        o.unf = underflow;
        return o;
    endfunction

    function automatic obs_t model_obs(input logic [1:0] pk);
        obs_t o;
        o.count = 3'(m_cnt);
        o.full = (m_cnt == 4);
        o.empty = (m_cnt == 0);
        o.ovf = m_ovf;
        o.unf = m_unf;
        o.top = 8'h00;
        if (m_cnt > 0) o.top = m_mem[m_cnt-1];
        o.peek_hit = (int'(pk) < m_cnt);
        o.peek_data = 8'h00;
        if (o.peek_hit) o.peek_data = m_mem[m_cnt-1-int'(pk)];
        return o;
    endfunction

    task automatic apply(input bit c, input bit pu, input bit po,
                         input logic [7:0] d, input bit e,
                         input logic [1:0] pk);
        bit ov, un;
        clr = c; push_en = pu; pop_en = po;
        din = d; err_clr = e; peek_idx = pk;
        ov = 1'b0; un = 1'b0;
        if (c) begin
            for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
            m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (pu && po) begin
                if (m_cnt == 0) begin m_mem[0] = d; m_cnt = 1; end
                else m_mem[m_cnt-1] = d;
            end else if (pu) begin
                if (m_cnt == 4) ov = 1'b1;
                else begin m_mem[m_cnt] = d; m_cnt++; end
            end else if (po) begin
                if (m_cnt == 0) un = 1'b1;
                else m_cnt--;
            end
            if (e) begin m_ovf = 1'b0; m_unf = 1'b0; end
            if (ov) m_ovf = 1'b1;
            if (un) m_unf = 1'b1;
        end
        exp_q.push_back(model_obs(pk));
        @(posedge clk);
        #1;
        got_q.push_back(sample());
        clr = 0; push_en = 0; pop_en = 0; err_clr = 0;
    endtask

    task automatic test_reset();
        obs_t e, g;
        apply(1, 0, 0, 8'h00, 0, 2'd0);
        vectors++;
        if (count !== 3'd0 || empty !== 1'b1 || top !== 8'h00 ||
            peek_hit !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got cnt=%0d empty=%b top=%h hit=%b want 0/1/00/0",
                     count, empty, top, peek_hit);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL reset: got %h want %h", g, e);
            end
        end
    endtask

    task automatic test_fill_drain();
        obs_t e, g;
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] tops [4] = '{8'h33, 8'h22, 8'h11, 8'h00};
        apply(1, 0, 0, 8'h00, 0, 2'd0);
        for (int i = 0; i < 4; i++) apply(0, 1, 0, vals[i], 0, 2'd0);
        vectors++;
        if (count !== 3'd4 || full !== 1'b1 || top !== 8'h44) begin
            miscompares++;
            $display("FAIL fill: got cnt=%0d full=%b top=%h want 4/1/44", count, full, top);
        end
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 1, 8'h00, 0, 2'd0);
            vectors++;
            if (top !== tops[i]) begin
                miscompares++;
                $display("FAIL drain_top: got %h want %h", top, tops[i]);
            end
        end
        vectors++;
        if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_end: got empty=%b ovf=%b unf=%b want 1/0/0",
                     empty, overflow, underflow);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL fill_drain: got %h want %h", g, e);
            end
        end
    endtask

    task automatic test_errors();
        obs_t e, g;
        for (int i = 0; i < 4; i++) apply(0, 1, 0, 8'h11 * 8'(i + 1), 0, 2'd0);
        apply(0, 1, 0, 8'h55, 0, 2'd0);
        vectors++;
        if (overflow !== 1'b1 || count !== 3'd4 || top !== 8'h44) begin
            miscompares++;
            $display("FAIL overflow: got ovf=%b cnt=%0d top=%h want 1/4/44",
                     overflow, count, top);
        end
        for (int i = 0; i < 4; i++) apply(0, 0, 1, 8'h00, 0, 2'd0);
        apply(0, 0, 1, 8'h00, 0, 2'd0);
        vectors++;
        if (underflow !== 1'b1 || count !== 3'd0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow: got unf=%b cnt=%0d ovf=%b want 1/0/1",
                     underflow, count, overflow);
        end
        apply(0, 0, 0, 8'h00, 1, 2'd0);
        vectors++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clr: got ovf=%b unf=%b want 0/0", overflow, underflow);
        end
        apply(0, 0, 1, 8'h00, 1, 2'd0);
        vectors++;
        if (underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL set_wins: got unf=%b want 1", underflow);
        end
        apply(0, 0, 0, 8'h00, 1, 2'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL errors: got %h want %h", g, e);
            end
        end
    endtask

    task automatic test_replace_top();
        obs_t e, g;
        apply(1, 0, 0, 8'h00, 0, 2'd0);
        apply(0, 1, 0, 8'h11, 0, 2'd0);
        apply(0, 1, 0, 8'h22, 0, 2'd0);
        apply(0, 1, 1, 8'hAA, 0, 2'd1);
        vectors++;
        if (count !== 3'd2 || top !== 8'hAA || peek_data !== 8'h11) begin
            miscompares++;
            $display("FAIL replace: got cnt=%0d top=%h peek=%h want 2/AA/11",
                     count, top, peek_data);
        end
        apply(0, 1, 0, 8'h33, 0, 2'd0);
        apply(0, 1, 0, 8'h44, 0, 2'd0);
        apply(0, 1, 1, 8'hBB, 0, 2'd3);
        vectors++;
        if (overflow !== 1'b0 || count !== 3'd4 || top !== 8'hBB || peek_data !== 8'h11) begin
            miscompares++;
            $display("FAIL replace_full: got ovf=%b cnt=%0d top=%h peek=%h want 0/4/BB/11",
                     overflow, count, top, peek_data);
        end
        apply(1, 0, 0, 8'h00, 0, 2'd0);
        apply(0, 1, 1, 8'h5A, 0, 2'd0);
        vectors++;
        if (count !== 3'd1 || top !== 8'h5A || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL replace_empty: got cnt=%0d top=%h unf=%b want 1/5A/0",
                     count, top, underflow);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL replace_top: got %h want %h", g, e);
            end
        end
    endtask

    task automatic test_peek();
        obs_t e, g;
        logic [7:0] want [4] = '{8'h33, 8'h22, 8'h11, 8'h00};
        apply(1, 0, 0, 8'h00, 0, 2'd0);
        apply(0, 1, 0, 8'h11, 0, 2'd0);
        apply(0, 1, 0, 8'h22, 0, 2'd0);
        apply(0, 1, 0, 8'h33, 0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 8'h00, 0, 2'(i));
            vectors++;
            if (peek_data !== want[i] || peek_hit !== (i < 3)) begin
                miscompares++;
                $display("FAIL peek%0d: got %h/%b want %h/%b",
                         i, peek_data, peek_hit, want[i], (i < 3));
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL peek: got %h want %h", g, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, g;
        apply(1, 0, 0, 8'h00, 0, 2'd0);
        for (int i = 0; i < 5; i++) apply(0, 1, 0, 8'h10 + 8'(i), 0, 2'd0);
        apply(0, 0, 1, 8'h00, 0, 2'd0);
        apply(1, 1, 0, 8'h77, 0, 2'd0);
        vectors++;
        if (count !== 3'd0 || empty !== 1'b1 || top !== 8'h00 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_mid: got cnt=%0d empty=%b top=%h ovf=%b want 0/1/00/0",
                     count, empty, top, overflow);
        end
        apply(0, 1, 0, 8'h77, 0, 2'd0);
        vectors++;
        if (count !== 3'd1 || top !== 8'h77) begin
            miscompares++;
            $display("FAIL push_after_clr: got cnt=%0d top=%h want 1/77", count, top);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL reset_mid: got %h want %h", g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        apply(1, 0, 0, 8'h00, 0, 2'd0);
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                apply(0, 1, 0, 8'(i / 2 + 1), 0, 2'd0);
                vectors++;
                if (count !== 3'd1 || top !== 8'(i / 2 + 1)) begin
                    miscompares++;
                    $display("FAIL b2b_push: got cnt=%0d top=%h want 1/%h",
                             count, top, 8'(i / 2 + 1));
                end
            end else begin
                apply(0, 0, 1, 8'h00, 0, 2'd0);
            end
        end
        vectors++;
        if (overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_end: got ovf=%b unf=%b empty=%b want 0/0/1",
                     overflow, underflow, empty);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL back_to_back: got %h want %h", g, e);
            end
        end
    endtask

    task automatic test_random();
        obs_t e, g;
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
                  8'($urandom), ($urandom_range(0, 7) == 0), 2'($urandom));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL random: got %h want %h", g, e);
            end
        end
    endtask

    initial begin
        clr = 1'b1; push_en = 1'b0; pop_en = 1'b0;
        din = 8'h00; err_clr = 1'b0; peek_idx = 2'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill_drain();
        test_errors();
        test_replace_top();
        test_peek();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
